// File: rtl/adc_sar_pkg.sv
// Shared definitions for the 12-bit SAR ADC control logic.
// Holds the converter resolution, the controller state type, and a helper
// that builds a one-hot trial mask for a given bit index.
package adc_sar_pkg;

  localparam int ADC_BITS = 12;
  localparam logic [3:0] MSB_IDX = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } sar_state_e;

  // One-hot mask with only bit k set
  function automatic logic [ADC_BITS-1:0] bit_mask(input logic [3:0] k);
    bit_mask = {{(ADC_BITS-1){1'b0}}, 1'b1} << k;
  endfunction

endpackage

// File: rtl/adc_sar_sample_timer.sv
// Sampling-phase length counter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : preload with SAMPLE_CYCLES-1 (first SAMPLE cycle follows)
//   dec      : count down by one while sampling continues
//   expire   : high when the current SAMPLE cycle is the last one
module adc_sar_sample_timer #(
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [3:0] cnt_r;

  // Down-counter: load, decrement, saturate at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= 4'(SAMPLE_CYCLES - 1);
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == 4'd0);

endmodule

// File: rtl/adc_sar_logic.sv
// Successive-approximation control logic for a 12-bit SAR ADC.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : conversion request (accepted in IDLE and DONE)
//   comp     : comparator decision, 1 = keep current trial bit
//   sample   : sampling switch enable (SAMPLE state)
//   comp_en  : comparator strobe (COMPARE state)
//   data     : DAC control word, drives the row/column decoder directly
//   result   : last completed conversion code
//   valid    : one-cycle pulse when result updates
//   busy     : high whenever not IDLE
// All outputs are flops loaded from the decode of the next state, so they
// line up with the state being entered and have no combinational input path.
module adc_sar_logic
  import adc_sar_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp,
  output logic                sample,
  output logic                comp_en,
  output logic [ADC_BITS-1:0] data,
  output logic [ADC_BITS-1:0] result,
  output logic                valid,
  output logic                busy
);

  sar_state_e          state_r, state_s;
  logic [3:0]          k_r, k_s;
  logic [ADC_BITS-1:0] work_r, work_s;
  logic [ADC_BITS-1:0] data_r, data_s;
  logic [ADC_BITS-1:0] result_r, result_s;
  logic                sample_r, comp_en_r, valid_r, busy_r;
  logic                tmr_load_s, tmr_dec_s, tmr_expire_s;

  adc_sar_sample_timer #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_s),
    .dec    (tmr_dec_s),
    .expire (tmr_expire_s)
  );

  // Next-state, bit index, working register and next output values
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    work_s     = work_r;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_SAMPLE;
          work_s     = {ADC_BITS{1'b0}};
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (tmr_expire_s) begin
          state_s = ST_SETTLE;
          k_s     = MSB_IDX;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_SETTLE: begin
        state_s = ST_COMPARE;
      end
      ST_COMPARE: begin
        // Decide the trial bit on the edge that ends COMPARE
        if (comp) begin
          work_s = work_r | bit_mask(k_r);
        end else begin
          work_s = work_r & ~bit_mask(k_r);
        end
        if (k_r == 4'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SETTLE;
          k_s     = k_r - 4'd1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s    = ST_SAMPLE;
          work_s     = {ADC_BITS{1'b0}};
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = MSB_IDX;
        work_s  = {ADC_BITS{1'b0}};
      end
    endcase

    // Output decode of the state being entered
    case (state_s)
      ST_SETTLE, ST_COMPARE: data_s = work_s | bit_mask(k_s);
      ST_DONE:               data_s = work_s;
      default:               data_s = {ADC_BITS{1'b0}};
    endcase
    if (state_s == ST_DONE) begin
      result_s = work_s;
    end else begin
      result_s = result_r;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      k_r       <= MSB_IDX;
      work_r    <= {ADC_BITS{1'b0}};
      data_r    <= {ADC_BITS{1'b0}};
      result_r  <= {ADC_BITS{1'b0}};
      sample_r  <= 1'b0;
      comp_en_r <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      k_r       <= k_s;
      work_r    <= work_s;
      data_r    <= data_s;
      result_r  <= result_s;
      sample_r  <= (state_s == ST_SAMPLE);
      comp_en_r <= (state_s == ST_COMPARE);
      valid_r   <= (state_s == ST_DONE);
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign sample  = sample_r;
  assign comp_en = comp_en_r;
  assign data    = data_r;
  assign result  = result_r;
  assign valid   = valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_adc_sar_logic.sv
// Self-checking bench for adc_sar_logic.
// The reference model tracks only "cycles since the conversion started" and
// derives every output from the final code the comparator must produce: in
// the trial for bit k, data shows the final code's bits above k plus bit k.
module tb_adc_sar_logic;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst, start, comp;
  logic        sample, comp_en, valid, busy;
  logic [11:0] data, result;

  int          mode;        // 0: comp tied 0, 1: comp tied 1, 2: vin comparator
  logic [11:0] vin;
  logic        junk;
  logic        chk_en;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          valid_cyc;
  int          valid_cnt;
  int          s_cyc;
  logic [11:0] trials[$];

  int          m_n;         // 0 = idle, 1..S sample, S+1..S+24 trials, S+25 done
  logic [11:0] m_result;

  adc_sar_logic #(.SAMPLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .comp    (comp),
    .sample  (sample),
    .comp_en (comp_en),
    .data    (data),
    .result  (result),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Bench comparator; random junk outside the strobe must have no effect
  assign comp = comp_en ? ((mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (vin >= data)) : junk;

  function automatic logic [11:0] exp_code();
    if (mode == 0) return 12'h000;
    else if (mode == 1) return 12'hFFF;
    else return vin;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: conversion progress counter and result holding register
  always @(posedge clk) begin
    cyc <= cyc + 1;
    junk <= 1'($urandom);
    if (rst) begin
      m_n      <= 0;
      m_result <= 12'h000;
    end else begin
      if (m_n == 0) m_n <= start ? 1 : 0;
      else if (m_n == S + 25) m_n <= start ? 1 : 0;
      else m_n <= m_n + 1;
      if (m_n == S + 24) m_result <= exp_code();
    end
  end

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    int j, k;
    logic [11:0] code, e_data;
    logic e_sample, e_comp_en, e_busy, e_valid;
    if (chk_en) begin
      code = exp_code();
      e_sample = 1'b0; e_comp_en = 1'b0; e_valid = 1'b0;
      e_busy = (m_n != 0);
      e_data = 12'h000;
      if (m_n >= 1 && m_n <= S) begin
        e_sample = 1'b1;
      end else if (m_n > S && m_n <= S + 24) begin
        j = m_n - S - 1;
        k = 11 - j / 2;
        e_comp_en = (j % 2) == 1;
        e_data = 12'((int'(code) & ~((2 << k) - 1)) | (1 << k));
      end else if (m_n == S + 25) begin
        e_valid = 1'b1;
        e_data = code;
      end
      check("cycle", {4'h0, sample, comp_en, busy, valid, data, result},
            {4'h0, e_sample, e_comp_en, e_busy, e_valid, e_data, m_result});
      if (comp_en) trials.push_back(data);
      if (valid) begin
        valid_cyc = cyc;
        valid_cnt++;
      end
    end
  end

  task automatic pulse_start();
    trials.delete();
    valid_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_k5_compare();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (comp_en && (data & 12'h03F) == 12'h020) seen = 1'b1;
    end
    if (!seen) check("k5_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0; vin = 12'h000; chk_en = 1'b0;
    valid_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_result", result, 12'h000);
    check("rst_busy", busy, 0);

    // comp tied 1
    mode = 1;
    pulse_start();
    wait_valid();
    repeat (3) @(negedge clk);
    check("ones_ntrials", trials.size(), 12);
    check("ones_t0", trials[0], 12'h800);
    check("ones_t1", trials[1], 12'hC00);
    check("ones_t2", trials[2], 12'hE00);
    check("ones_t11", trials[11], 12'hFFF);
    check("ones_result", result, 12'hFFF);
    check("ones_latency", valid_cyc - s_cyc, 29);
    check("ones_nvalid", valid_cnt, 1);

    // comp tied 0
    mode = 0;
    pulse_start();
    wait_valid();
    repeat (2) @(negedge clk);
    check("zeros_t0", trials[0], 12'h800);
    check("zeros_t1", trials[1], 12'h400);
    check("zeros_t2", trials[2], 12'h200);
    check("zeros_t11", trials[11], 12'h001);
    check("zeros_result", result, 12'h000);

    // behavioural comparator, vin = A5C
    mode = 2; vin = 12'hA5C;
    pulse_start();
    wait_valid();
    repeat (2) @(negedge clk);
    check("vin_t0", trials[0], 12'h800);
    check("vin_t1", trials[1], 12'hC00);
    check("vin_t2", trials[2], 12'hA00);
    check("vin_t3", trials[3], 12'hB00);
    check("vin_t4", trials[4], 12'hA80);
    check("vin_t5", trials[5], 12'hA40);
    check("vin_result", result, 12'hA5C);

    // start re-pulsed during SETTLE/COMPARE, then held in DONE
    vin = 12'h123;
    pulse_start();
    repeat (S + 2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_valid();
    check("ign_nvalid", valid_cnt, 1);
    check("ign_result", result, 12'h123);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("b2b_sample", sample, 1);
    check("b2b_hold", result, 12'h123);
    vin = 12'h7FF;
    wait_valid();
    check("b2b_result", result, 12'h7FF);
    repeat (2) @(negedge clk);

    // reset during COMPARE of bit 5
    vin = 12'h3C3;
    pulse_start();
    wait_k5_compare();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 12'h000);
    check("abort_valid", valid, 0);
    check("abort_nvalid", valid_cnt, 0);
    vin = 12'h5A5;
    pulse_start();
    wait_valid();
    check("fresh_result", result, 12'h5A5);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
